clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//   Time-setting front end for a 24h clock core. It generates the one-second
//   advance enable while running and lets the user edit hours, then minutes,
//   with two buttons. The edited value is handed to the core with a one-cycle
//   load pulse.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   RUN       | prescaler running, sec_tick pulses, buttons only start an edit
//   SET_HOUR  | load_hour edited by btn_inc, blink toggles
//   SET_MIN   | load_min edited by btn_inc, blink toggles
//   COMMIT    | single cycle, load = 1, then back to RUN
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   btn_mode   debounced level, rising edge advances the edit mode
//   btn_inc    debounced level, rising edge (and auto-repeat) increments
//   cur_hour   live hour from the clock core
//   cur_min    live minute from the clock core
//   sec_tick   one-cycle seconds-advance enable to the core
//   load       one-cycle pulse, core loads load_hour/load_min, clears seconds
//   load_hour  edited hour
//   load_min   edited minute
//   mode       0=RUN 1=SET_HOUR 2=SET_MIN 3=COMMIT
//   blink      display-visible flag for the field being edited
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int CLK_DIV       = 100,
    parameter int REPEAT_CYCLES = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic       sec_tick,
    output logic       load,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_COMMIT   = 2'd3
    } state_t;

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (CLK_DIV / 2 > 1) ? $clog2(CLK_DIV / 2) : 1;
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(CLK_DIV / 2 - 1);
    localparam logic [RW-1:0] REP_MAX   = RW'(REPEAT_CYCLES);

    state_t        r_state;
    logic          r_mode_d;
    logic          r_inc_d;
    logic [PW-1:0] r_pre;
    logic [BW-1:0] r_blink_cnt;
    logic [RW-1:0] r_rep;
    logic          r_blink;
    logic          r_load;
    logic [4:0]    r_load_hour;
    logic [5:0]    r_load_min;

    logic w_mode_edge;
    logic w_inc_edge;
    logic w_in_set;
    logic w_rep_fire;
    logic w_inc_evt;

    assign w_mode_edge = btn_mode & ~r_mode_d;
    assign w_inc_edge  = btn_inc & ~r_inc_d;
    assign w_in_set    = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN);

    // r_rep counts held cycles after the edge (the edge cycle itself is not
    // counted); once REPEAT_CYCLES of them have elapsed the next held cycle
    // produces the repeat increment and the count restarts.
    assign w_rep_fire  = w_in_set & btn_inc & r_inc_d & (r_rep == REP_MAX);

    // A mode edge in the same cycle always wins; the increment is dropped.
    assign w_inc_evt   = w_in_set & (w_inc_edge | w_rep_fire) & ~w_mode_edge;

    assign sec_tick  = (r_state == ST_RUN) && (r_pre == PRE_MAX);
    assign load      = r_load;
    assign load_hour = r_load_hour;
    assign load_min  = r_load_min;
    assign mode      = r_state;
    assign blink     = r_blink;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_mode_d    <= 1'b0;
            r_inc_d     <= 1'b0;
            r_pre       <= '0;
            r_blink_cnt <= '0;
            r_rep       <= '0;
            r_blink     <= 1'b0;
            r_load      <= 1'b0;
            r_load_hour <= '0;
            r_load_min  <= '0;
        end else begin
            r_mode_d <= btn_mode;
            r_inc_d  <= btn_inc;
            r_load   <= 1'b0;

            case (r_state)
                ST_RUN: begin
                    r_rep       <= '0;
                    r_blink_cnt <= '0;
                    if (w_mode_edge) begin
                        r_state     <= ST_SET_HOUR;
                        r_load_hour <= cur_hour;
                        r_load_min  <= cur_min;
                        r_pre       <= '0;
                        r_blink     <= 1'b1;
                    end else begin
                        r_blink <= 1'b0;
                        r_pre   <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
                    end
                end

                ST_SET_HOUR, ST_SET_MIN: begin
                    r_pre <= '0;
                    if (w_mode_edge) begin
                        r_rep       <= '0;
                        r_blink_cnt <= '0;
                        if (r_state == ST_SET_HOUR) begin
                            r_state <= ST_SET_MIN;
                            r_blink <= 1'b1;
                        end else begin
                            r_state <= ST_COMMIT;
                            r_blink <= 1'b0;
                            r_load  <= 1'b1;
                        end
                    end else begin
                        if (!btn_inc || w_inc_edge || (r_rep == REP_MAX))
                            r_rep <= '0;
                        else
                            r_rep <= r_rep + 1'b1;

                        if (w_inc_evt) begin
                            r_blink     <= 1'b1;
                            r_blink_cnt <= '0;
                            // Out-of-range captured values wrap to 0 as well.
                            if (r_state == ST_SET_HOUR)
                                r_load_hour <= (r_load_hour >= 5'd23) ? 5'd0 : r_load_hour + 5'd1;
                            else
                                r_load_min  <= (r_load_min >= 6'd59) ? 6'd0 : r_load_min + 6'd1;
                        end else if (r_blink_cnt == BLINK_MAX) begin
                            r_blink     <= ~r_blink;
                            r_blink_cnt <= '0;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                    end
                end

                ST_COMMIT: begin
                    r_state     <= ST_RUN;
                    r_pre       <= '0;
                    r_rep       <= '0;
                    r_blink     <= 1'b0;
                    r_blink_cnt <= '0;
                end

                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

    localparam int CLK_DIV       = 4;
    localparam int REPEAT_CYCLES = 5;

    logic       clk;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic       sec_tick;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [1:0] mode;
    logic       blink;

    int checks = 0;
    int errors = 0;

    clock_set_ctrl #(
        .CLK_DIV       (CLK_DIV),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .sec_tick  (sec_tick),
        .load      (load),
        .load_hour (load_hour),
        .load_min  (load_min),
        .mode      (mode),
        .blink     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic       i;
        logic [1:0] mode;
        logic       load;
        logic [4:0] lh;
        logic [5:0] lm;
        logic       tick;
        logic       blink;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive at a falling edge, let one rising edge pass, return at the next
    // falling edge where outputs are sampled.
    task automatic step(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // cur_hour=23, cur_min=59: full set sequence, ignored RUN inc, blink
        tbl[0]  = '{1'b1, 1'b0, 2'd1, 1'b0, 5'd23, 6'd59, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 5'd0,  6'd59, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 2'd1, 1'b0, 5'd0,  6'd59, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 2'd2, 1'b0, 5'd0,  6'd59, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 5'd0,  6'd0,  1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 2'd2, 1'b0, 5'd0,  6'd0,  1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 2'd3, 1'b1, 5'd0,  6'd0,  1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  6'd0,  1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  6'd0,  1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  6'd0,  1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  6'd0,  1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'd0, 1'b0, 5'd0,  6'd0,  1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 2'd1, 1'b0, 5'd23, 6'd59, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 2'd1, 1'b0, 5'd23, 6'd59, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 2'd1, 1'b0, 5'd23, 6'd59, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 2'd1, 1'b0, 5'd23, 6'd59, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 2'd1, 1'b0, 5'd23, 6'd59, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 2'd1, 1'b0, 5'd23, 6'd59, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 2'd1, 1'b0, 5'd0,  6'd59, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 2'd1, 1'b0, 5'd0,  6'd59, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 2'd1, 1'b0, 5'd0,  6'd59, 1'b0, 1'b0};

        reset    = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cur_hour = 5'd0;
        cur_min  = 6'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mode",  int'(mode),      0);
        chk("rst_load",  int'(load),      0);
        chk("rst_tick",  int'(sec_tick),  0);
        chk("rst_blink", int'(blink),     0);
        chk("rst_lh",    int'(load_hour), 0);
        chk("rst_lm",    int'(load_min),  0);

        // Free run: tick in cycles 4, 8, 12 after release, never a load
        @(posedge clk);
        #2 reset = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk($sformatf("free_tick_c%0d", n), int'(sec_tick), (n % 4 == 0) ? 1 : 0);
            chk($sformatf("free_load_c%0d", n), int'(load), 0);
        end

        // Table: full set sequence, commit, ignored inc, blink pattern
        cur_hour = 5'd23;
        cur_min  = 6'd59;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].m, tbl[i].i);
            chk($sformatf("v%0d_mode", i),  int'(mode),      int'(tbl[i].mode));
            chk($sformatf("v%0d_load", i),  int'(load),      int'(tbl[i].load));
            chk($sformatf("v%0d_lh", i),    int'(load_hour), int'(tbl[i].lh));
            chk($sformatf("v%0d_lm", i),    int'(load_min),  int'(tbl[i].lm));
            chk($sformatf("v%0d_tick", i),  int'(sec_tick),  int'(tbl[i].tick));
            chk($sformatf("v%0d_blink", i), int'(blink),     int'(tbl[i].blink));
        end

        // Auto-repeat: SET_MIN from 10, btn_inc held 16 cycles
        cur_hour = 5'd3;
        cur_min  = 6'd10;
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("rep_mode", int'(mode), 2);
        chk("rep_start", int'(load_min), 10);
        step(1'b0, 1'b1);
        chk("rep_first", int'(load_min), 11);
        for (int k = 2; k <= 16; k++) step(1'b0, 1'b1);
        chk("rep_held16", int'(load_min), 13);
        step(1'b0, 1'b0);
        chk("rep_release", int'(load_min), 13);
        chk("rep_lh", int'(load_hour), 3);

        // Simultaneous mode and inc edges in SET_HOUR
        cur_hour = 5'd5;
        cur_min  = 6'd42;
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("sim_pre_lh", int'(load_hour), 5);
        step(1'b1, 1'b1);
        chk("sim_mode", int'(mode), 2);
        chk("sim_lh", int'(load_hour), 5);
        chk("sim_lm", int'(load_min), 42);
        step(1'b0, 1'b0);
        chk("sim_lh_after", int'(load_hour), 5);

        // Reset mid-edit in SET_MIN
        step(1'b0, 1'b1);
        chk("mid_lm_inc", int'(load_min), 43);
        #1 reset = 1'b0;
        #1;
        chk("mid_mode", int'(mode), 0);
        chk("mid_load", int'(load), 0);
        chk("mid_lm", int'(load_min), 0);
        chk("mid_lh", int'(load_hour), 0);
        btn_inc = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk($sformatf("mid_tick_%0d", n), int'(sec_tick), 0);
            chk($sformatf("mid_hold_load_%0d", n), int'(load), 0);
        end
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b0);
            chk($sformatf("post_load_%0d", n), int'(load), 0);
            chk($sformatf("post_mode_%0d", n), int'(mode), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
